// File: rtl/mem_sched_pkg.sv
// Shared types and defaults for the memory access scheduler.
package mem_sched_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_access_scheduler_rr_arbiter.sv
// Two-requester round-robin arbiter; one-hot grant {rd, wr}, combinational.
// last_grant resets to read so the first contested grant goes to write.
module rr_arbiter_2
  import mem_sched_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_elig,
  input  logic       i_rd_elig,
  input  logic       i_take,
  output logic [1:0] o_gnt
);

  grant_t r_last_grant;

  always_comb begin
    o_gnt = {i_rd_elig, i_wr_elig};
    if (i_wr_elig && i_rd_elig) begin
      o_gnt = (r_last_grant == GRANT_RD) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_last_grant <= GRANT_RD;
    end else if (i_take && (o_gnt != 2'b00)) begin
      r_last_grant <= o_gnt[0] ? GRANT_WR : GRANT_RD;
    end
  end

endmodule

// File: rtl/mem_access_scheduler.sv
// Arbitrates one writer and one reader onto a FIFO memory driver, one access per 2 cycles.
// Optional auto-drain on full memory is enabled by defining MEM_SCHED_AUTO_DRAIN_EN.
module mem_access_scheduler
  import mem_sched_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  output logic              o_rd_ack,
  output logic              o_mem_wr_en,
  output logic [DATA_W-1:0] o_mem_wr_data,
  output logic              o_mem_rd_en,
  input  logic              i_mem_full,
  input  logic              i_mem_empty,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_err
);

  state_t             r_state;
  state_t             w_next;
  logic [LVL_W-1:0]   r_level;
  logic               r_err;
  logic [DATA_W-1:0]  r_wr_data;
  logic [1:0]         w_gnt;
  logic               w_take;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic               w_drain_rd;
  logic               w_flag_bad;

`ifdef MEM_SCHED_AUTO_DRAIN_EN
  assign w_take = (r_state == IDLE) && !i_mem_full;
`else
  assign w_take = (r_state == IDLE);
`endif

  rr_arbiter_2 u_arb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_elig (i_wr_req && !i_mem_full),
    .i_rd_elig (i_rd_req && !i_mem_empty),
    .i_take    (w_take),
    .o_gnt     (w_gnt)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
`ifdef MEM_SCHED_AUTO_DRAIN_EN
        if (i_mem_full)    w_next = DRAIN;
        else
`endif
        if (w_gnt[0])      w_next = WR;
        else if (w_gnt[1]) w_next = RD;
      end
      WR:      w_next = IDLE;
      RD:      w_next = IDLE;
      DRAIN:   if (r_level <= LVL_W'(1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_wr_acc   = (r_state == WR);
  assign w_rd_acc   = (r_state == RD);
  assign w_drain_rd = (r_state == DRAIN) && (r_level != '0);
  assign w_flag_bad = (i_mem_full != (r_level == LVL_W'(DEPTH))) ||
                      (i_mem_empty != (r_level == '0));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_level   <= '0;
      r_err     <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == WR) r_wr_data <= i_wr_data;
      if (r_state == IDLE && w_flag_bad)   r_err     <= 1'b1;
      // Saturating count: a gated grant never hits a bound, this only guards bad flags.
      if (w_wr_acc && r_level != LVL_W'(DEPTH)) begin
        r_level <= r_level + 1'b1;
      end else if ((w_rd_acc || w_drain_rd) && r_level != '0) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  assign o_mem_wr_en   = w_wr_acc;
  assign o_wr_ack      = w_wr_acc;
  assign o_mem_rd_en   = w_rd_acc || w_drain_rd;
  assign o_rd_ack      = w_rd_acc;
  assign o_mem_wr_data = r_wr_data;
  assign o_level       = r_level;
  assign o_err         = r_err;

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Scoreboard bench for mem_access_scheduler with a behavioural FIFO memory driver.
module tb_mem_access_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_req = 1'b0;
  logic       rd_req = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ack, rd_ack, mem_wr_en, mem_rd_en, mem_full, mem_empty, err;
  logic [7:0] mem_wr_data;
  logic [2:0] level;

  logic       force_empty_en = 1'b0;
  logic       force_empty_val = 1'b0;
  int         mem_cnt;
  logic [7:0] mem_q[$];
  logic [7:0] obs_rd_q[$];
  logic [7:0] exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  byte        exp_gnt_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_scheduler dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_req      (wr_req),
    .i_wr_data     (wr_data),
    .o_wr_ack      (wr_ack),
    .i_rd_req      (rd_req),
    .o_rd_ack      (rd_ack),
    .o_mem_wr_en   (mem_wr_en),
    .o_mem_wr_data (mem_wr_data),
    .o_mem_rd_en   (mem_rd_en),
    .i_mem_full    (mem_full),
    .i_mem_empty   (mem_empty),
    .o_level       (level),
    .o_err         (err)
  );

  // Memory driver model: flags change the cycle after a strobe.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q.delete();
      mem_cnt <= 0;
    end else begin
      if (mem_wr_en && mem_q.size() < 4) mem_q.push_back(mem_wr_data);
      if (mem_rd_en && mem_q.size() > 0) obs_rd_q.push_back(mem_q.pop_front());
      mem_cnt <= mem_cnt + ((mem_wr_en && mem_cnt < 4) ? 1 : 0) - ((mem_rd_en && mem_cnt > 0) ? 1 : 0);
    end
  end

  assign mem_full  = (mem_cnt == 4);
  assign mem_empty = force_empty_en ? force_empty_val : (mem_cnt == 0);

  task automatic wait_ack(input bit is_wr, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (is_wr ? wr_ack : rd_ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_wr_en, mem_rd_en, wr_ack, rd_ack, err} !== 5'b0)
      $display("FAIL reset_strobes: got %b want 00000", {mem_wr_en, mem_rd_en, wr_ack, rd_ack, err});
    else n_pass++;
    n_checks++;
    if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level);
    else n_pass++;
    n_checks++;
    if (mem_wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", mem_wr_data);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    logic [7:0] e;
    wr_data = 8'h01;
    wr_req  = 1'b1;
    exp_wr_q.push_back(8'h01);
    exp_rd_q.push_back(8'h01);
    @(negedge clk);
    n_checks++;
    if (!(mem_wr_en === 1'b1 && wr_ack === 1'b1))
      $display("FAIL single_latency: wr_en=%b ack=%b want 1 1", mem_wr_en, wr_ack);
    else n_pass++;
    e = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : 8'hxx;
    n_checks++;
    if (mem_wr_data !== e) $display("FAIL single_data: got %h want %h", mem_wr_data, e);
    else n_pass++;
    wr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({level, err, mem_wr_en} !== {3'd1, 1'b0, 1'b0})
      $display("FAIL single_after: level=%0d err=%b wr_en=%b want 1 0 0", level, err, mem_wr_en);
    else n_pass++;
  endtask

  task automatic test_fill;
    bit got;
    logic [7:0] e;
    for (int k = 2; k <= 4; k++) begin
      wr_data = 8'(k);
      wr_req  = 1'b1;
      exp_wr_q.push_back(8'(k));
      exp_rd_q.push_back(8'(k));
      wait_ack(1'b1, 10, got);
      e = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : 8'hxx;
      n_checks++;
      if (!got || mem_wr_data !== e)
        $display("FAIL fill_write: ack=%b data=%h want ack=1 data=%h", got, mem_wr_data, e);
      else n_pass++;
      wr_req = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (level !== 3'd4) $display("FAIL fill_level: got %0d want 4", level);
    else n_pass++;
`ifndef MEM_SCHED_AUTO_DRAIN_EN
    wr_data = 8'h05;
    wr_req  = 1'b1;
    wait_ack(1'b1, 12, got);
    n_checks++;
    if (got !== 1'b0) $display("FAIL full_blocks_write: ack=%b want 0", got);
    else n_pass++;
    wr_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rd_req = 1'b1;
      wait_ack(1'b0, 10, got);
      rd_req = 1'b0;
      @(negedge clk);
      e = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 8'hxx;
      n_checks++;
      if (!got || obs_rd_q.size() == 0 || obs_rd_q[0] !== e)
        $display("FAIL read_order: ack=%b data=%h want ack=1 data=%h", got,
                 (obs_rd_q.size() > 0) ? obs_rd_q[0] : 8'hxx, e);
      else n_pass++;
      if (obs_rd_q.size() > 0) void'(obs_rd_q.pop_front());
    end
`endif
  endtask

`ifdef MEM_SCHED_AUTO_DRAIN_EN
  task automatic test_auto_drain;
    int n_rd = 0, n_ack = 0, first = -1, last = -1;
    rd_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        n_rd++;
        if (first < 0) first = i;
        last = i;
      end
      if (rd_ack) n_ack++;
    end
    rd_req = 1'b0;
    n_checks++;
    if (n_rd !== 4 || last - first !== 3)
      $display("FAIL drain_strobes: count=%0d span=%0d want 4 3", n_rd, last - first);
    else n_pass++;
    n_checks++;
    if (n_ack !== 0) $display("FAIL drain_no_ack: got %0d want 0", n_ack);
    else n_pass++;
    n_checks++;
    if (level !== 3'd0) $display("FAIL drain_level: got %0d want 0", level);
    else n_pass++;
    exp_rd_q.delete();
    obs_rd_q.delete();
  endtask
`endif

  task automatic test_contention;
    byte        kind;
    byte        ek;
    logic [7:0] e;
    wr_data = 8'h10;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    exp_gnt_q = '{"W", "R", "W", "R"};
    exp_wr_q.push_back(8'h10);
    exp_wr_q.push_back(8'h11);
    exp_rd_q.push_back(8'h10);
    exp_rd_q.push_back(8'h11);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (mem_wr_en && mem_rd_en) $display("FAIL strobe_overlap: cycle %0d both strobes high", i);
      else n_pass++;
      kind = mem_wr_en ? "W" : (mem_rd_en ? "R" : "-");
      ek   = (i % 2 == 1) ? "-" : ((exp_gnt_q.size() > 0) ? exp_gnt_q.pop_front() : "?");
      n_checks++;
      if (kind !== ek) $display("FAIL contention_order: cycle %0d got %c want %c", i, kind, ek);
      else n_pass++;
      if (kind == "W") begin
        e = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : 8'hxx;
        n_checks++;
        if (mem_wr_data !== e) $display("FAIL contention_data: got %h want %h", mem_wr_data, e);
        else n_pass++;
        wr_data = 8'h11;
      end
      if (i == 7) begin
        wr_req = 1'b0;
        rd_req = 1'b0;
      end
    end
    @(negedge clk);
    while (obs_rd_q.size() > 0 && exp_rd_q.size() > 2) begin
      e = exp_rd_q.pop_front();
      n_checks++;
      if (obs_rd_q[0] !== e) $display("FAIL contention_read: got %h want %h", obs_rd_q[0], e);
      else n_pass++;
      void'(obs_rd_q.pop_front());
    end
    n_checks++;
    if (level !== 3'(exp_rd_q.size()))
      $display("FAIL contention_level: got %0d want %0d", level, exp_rd_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_access;
    wr_data = 8'hAA;
    wr_req  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_wr_en !== 1'b1) $display("FAIL mid_reset_pre: wr_en=%b want 1", mem_wr_en);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_wr_en, wr_ack, mem_rd_en, rd_ack, err, level, mem_wr_data} !== '0)
      $display("FAIL mid_reset_outputs: wr_en=%b ack=%b rd_en=%b rd_ack=%b err=%b level=%0d data=%h want all 0",
               mem_wr_en, wr_ack, mem_rd_en, rd_ack, err, level, mem_wr_data);
    else n_pass++;
    wr_req = 1'b0;
    exp_rd_q.delete();
    obs_rd_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    force_empty_en  = 1'b1;
    force_empty_val = 1'b0;
    wr_data = 8'h33;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_wr_en, mem_rd_en} !== 2'b10)
      $display("FAIL post_reset_first_grant: wr_en=%b rd_en=%b want 1 0", mem_wr_en, mem_rd_en);
    else n_pass++;
    wr_req = 1'b0;
    rd_req = 1'b0;
    force_empty_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flag_mismatch;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_clean: got %b want 0", err);
    else n_pass++;
    force_empty_en  = 1'b1;
    force_empty_val = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err);
    else n_pass++;
    force_empty_en = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_reset: got %b want 0", err);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill();
`ifdef MEM_SCHED_AUTO_DRAIN_EN
    test_auto_drain();
`endif
    test_contention();
    test_reset_mid_access();
    test_flag_mismatch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_scheduler.md
# mem_access_scheduler

Controller that shares the FIFO-style memory driver between one write requester (the button-counter value source) and one read requester (the display/consumer side). It arbitrates round-robin, issues single-cycle `wr_en`/`rd_en` strobes to the memory driver, and gates accesses with the driver's `full`/`empty` flags. It keeps a shadow occupancy count and flags any mismatch with those flags. It sits between `button_counter` and `memory_driver`.

## Interface
- `DATA_W`, default 8: width of one write word.
- `DEPTH`, default 4: number of memory entries; the driver's concatenated output is `DEPTH*DATA_W` (32) bits.
- `clk` input 1: the single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-low reset.
- `wr_req` input 1: write request; held, with `wr_data`, until `wr_ack`.
- `wr_data` input DATA_W: word to write.
- `wr_ack` output 1: one-cycle pulse when the write strobe is issued.
- `rd_req` input 1: read request; held until `rd_ack`.
- `rd_ack` output 1: one-cycle pulse when the read strobe is issued.
- `mem_wr_en` output 1: write strobe to the memory driver.
- `mem_wr_data` output DATA_W: registered copy of `wr_data` at grant.
- `mem_rd_en` output 1: read strobe to the memory driver.
- `mem_full` input 1: full flag from the memory driver.
- `mem_empty` input 1: empty flag from the memory driver.
- `level` output clog2(DEPTH+1): shadow occupancy.
- `err` output 1: sticky mismatch between the flags and `level`.

## Operation
- The FSM is defined in the package and has four states: IDLE, WR, RD, DRAIN.
- **IDLE:**
  - A write is eligible when `wr_req && !mem_full`.
  - A read is eligible when `rd_req && !mem_empty`.
  - If only one request is eligible, the FSM goes to WR or RD.
  - If both are eligible, the request opposite to `last_grant` wins.
- **WR:** asserts `mem_wr_en`, `wr_ack`, and `mem_wr_data`; `level` increments; `last_grant` becomes write; next state is IDLE.
- **RD:** asserts `mem_rd_en` and `rd_ack`; `level` decrements; `last_grant` becomes read; next state is IDLE.
- **Flag timing:** the memory flags update the cycle after a strobe, so every access is followed by at least one IDLE cycle. Maximum throughput is one access per 2 cycles.
- **Request withdrawal:** requests are sampled only in IDLE. A request withdrawn before it is sampled is never granted. Once a grant is taken, the access always completes.
- **Full memory:** writes are held off and no `wr_ack` is issued. Reads proceed.
- **Empty memory:** reads are held off. Writes proceed.
- **Flag check (IDLE only):**
  - `err` sets when `mem_full != (level==DEPTH)` or `mem_empty != (level==0)`.
  - `err` clears only on reset. Arbitration continues while it is set.
- **Saturation:** `level` never wraps; it saturates at 0 and at DEPTH. A gated grant can never reach a bound in normal operation.

## Timing
- **Reset:** while `rst` is low, all outputs are 0, `level` is 0, `err` is 0, the state is IDLE, and `last_grant` is read. As a result, the first contested grant goes to write.
- **Reset mid-access:** the strobe drops immediately (asynchronously) and no ack is issued.
- **Grant latency:** a request sampled in IDLE at cycle N produces its strobe and ack at cycle N+1. The FSM is back in IDLE at N+2.
- **Registered outputs:** `mem_wr_data` is registered at the IDLE→WR transition and is stable during the `mem_wr_en` cycle.
- **Strobe exclusivity:** `mem_wr_en` and `mem_rd_en` are never high in the same cycle.
- **Back-to-back contention:** requests held continuously on both sides alternate W, R, W, R…, with one IDLE cycle between accesses.

## Configuration
- `MEM_SCHED_AUTO_DRAIN_EN` defined:
  - IDLE with `mem_full` high enters DRAIN. DRAIN has priority over both requests.
  - DRAIN asserts `mem_rd_en` every cycle while `level>0`, decrementing `level` each cycle, and returns to IDLE when `level` reaches 0.
  - DRAIN reads never pulse `rd_ack`. `wr_req` and `rd_req` are ignored throughout DRAIN.
  - With DEPTH=4, a drain is exactly 4 consecutive read strobes.
- `MEM_SCHED_AUTO_DRAIN_EN` undefined:
  - The DRAIN state is unreachable; a full memory only blocks writes.

## Structure
- Package `mem_sched_pkg` contains:
  - the state enum (IDLE, WR, RD, DRAIN);
  - the grant encoding (GRANT_WR/GRANT_RD);
  - default DEPTH and DATA_W constants.
- Sub-module `rr_arbiter_2` is a two-requester round-robin arbiter with the `last_grant` register. It takes the eligibility inputs and emits a one-hot grant.
- The FSM, `level` counter and `err` logic stay in the top module.

## Test plan
- **Single write:** after reset, `wr_req=1`, `wr_data=8'h01`. Expect `mem_wr_en`/`wr_ack` one cycle after sampling, `mem_wr_data=8'h01`, `level=1`, `err=0`.
- **Fill:** 4 writes of 1..4 with a memory model. Expect `level=4`. A 5th `wr_req` gets no `wr_ack` for at least 10 cycles (macro undefined).
- **Contention:** both requests held with `level=2`. Expect grants W, R, W, R, with an IDLE cycle between strobes and strobes never overlapping.
- **Auto-drain:** macro defined, fill to 4. Expect 4 consecutive `mem_rd_en` cycles, no `rd_ack`, `level=0`, return to IDLE. A held `rd_req` during the drain is not acked.
- **Flag mismatch:** force `mem_empty=0` while `level=0` in IDLE. Expect `err=1`, staying high until `rst` goes low.
- **Reset mid-access:** pull `rst` low during the WR cycle. Expect `mem_wr_en=0` immediately and all outputs 0. After release, the first contested grant goes to write.
